// File: rtl/arith_pkg.sv
// Shared arithmetic-library types and helpers: divider state encoding,
// counter sizing and the most-negative-value constant.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    // Iteration counter holds N-1 down to 0.
    function automatic int unsigned div_cnt_w(input int unsigned n);
        return (n < 3) ? 1 : $clog2(n);
    endfunction

    // 1'b1 followed by zeros at width n; callers truncate to their width.
    function automatic logic [63:0] div_most_neg(input int unsigned n);
        return 64'(1) << (n - 1);
    endfunction

endpackage

// File: rtl/div_sub_step.sv
// Single restoring-division step: N+1-bit trial subtract of the divisor
// magnitude from the shifted partial remainder.
module div_sub_step #(
    parameter int unsigned N = 32
) (
    input  logic [N:0]   shifted_i,
    input  logic [N-1:0] divisor_i,
    output logic [N-1:0] diff_c_o,
    output logic         nonneg_c_o
);

    logic [N:0] trial;

    assign trial      = shifted_i - {1'b0, divisor_i};
    // A non-negative result always fits in N bits since rem < |B|.
    assign diff_c_o   = trial[N-1:0];
    assign nonneg_c_o = ~trial[N];

endmodule

// File: rtl/seq_signed_divider.sv
// Iterative signed restoring divider with valid/ready handshakes; one
// quotient bit per cycle on magnitudes, sign fix-up in a final cycle.
module seq_signed_divider
    import arith_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] Quotient,
    output logic [N-1:0] Remainder,
    output logic         DivByZero,
    output logic         Overflow
);

    localparam int unsigned CNT_W    = div_cnt_w(N);
    localparam logic [N-1:0] MOST_NEG = N'(div_most_neg(N));

    div_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]   dq_q, dq_d;
    logic [N-1:0]   rem_q, rem_d;
    logic [N-1:0]   dvsr_q, dvsr_d;
    logic           sgn_quo_q, sgn_quo_d;
    logic           sgn_rem_q, sgn_rem_d;
    logic           ovf_pend_q, ovf_pend_d;
    logic [N-1:0]   quot_q, quot_d;
    logic [N-1:0]   remo_q, remo_d;
    logic           dbz_q, dbz_d;
    logic           ovf_q, ovf_d;
    logic           in_ready_q, in_ready_d;
    logic           out_valid_q, out_valid_d;

    logic [N:0]     shifted_c;
    logic [N-1:0]   diff_c;
    logic           nonneg_c;

    // Dividend MSB shifts into the partial remainder each iteration.
    assign shifted_c = {rem_q, dq_q[N-1]};

    div_sub_step #(.N(N)) u_step (
        .shifted_i  (shifted_c),
        .divisor_i  (dvsr_q),
        .diff_c_o   (diff_c),
        .nonneg_c_o (nonneg_c)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dq_d        = dq_q;
        rem_d       = rem_q;
        dvsr_d      = dvsr_q;
        sgn_quo_d   = sgn_quo_q;
        sgn_rem_d   = sgn_rem_q;
        ovf_pend_d  = ovf_pend_q;
        quot_d      = quot_q;
        remo_d      = remo_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (B == '0) begin
                        quot_d  = '1;
                        remo_d  = A;
                        dbz_d   = 1'b1;
                        ovf_d   = 1'b0;
                        state_d = DONE;
                    end else begin
                        // Negating MOST_NEG yields 2^(N-1) as an unsigned magnitude.
                        dq_d       = A[N-1] ? -A : A;
                        dvsr_d     = B[N-1] ? -B : B;
                        sgn_quo_d  = A[N-1] ^ B[N-1];
                        sgn_rem_d  = A[N-1];
                        ovf_pend_d = (A == MOST_NEG) && (B == '1);
                        rem_d      = '0;
                        cnt_d      = CNT_W'(N - 1);
                        state_d    = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = nonneg_c ? diff_c : shifted_c[N-1:0];
                dq_d  = {dq_q[N-2:0], nonneg_c};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                quot_d  = sgn_quo_q ? -dq_q : dq_q;
                remo_d  = sgn_rem_q ? -rem_q : rem_q;
                ovf_d   = ovf_pend_q;
                dbz_d   = 1'b0;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dq_q        <= '0;
            rem_q       <= '0;
            dvsr_q      <= '0;
            sgn_quo_q   <= 1'b0;
            sgn_rem_q   <= 1'b0;
            ovf_pend_q  <= 1'b0;
            quot_q      <= '0;
            remo_q      <= '0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dq_q        <= dq_d;
            rem_q       <= rem_d;
            dvsr_q      <= dvsr_d;
            sgn_quo_q   <= sgn_quo_d;
            sgn_rem_q   <= sgn_rem_d;
            ovf_pend_q  <= ovf_pend_d;
            quot_q      <= quot_d;
            remo_q      <= remo_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign Quotient  = quot_q;
    assign Remainder = remo_q;
    assign DivByZero = dbz_q;
    assign Overflow  = ovf_q;

endmodule

// File: tb/tb_seq_signed_divider.sv
// Self-checking bench for seq_signed_divider at N=8: directed corner cases,
// backpressure, mid-operation reset and random operands against an integer model.
module tb_seq_signed_divider;

    localparam int N = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] Quotient;
    logic [N-1:0] Remainder;
    logic         DivByZero;
    logic         Overflow;

    int errors = 0;
    int checks = 0;

    seq_signed_divider #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .DivByZero (DivByZero),
        .Overflow  (Overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division truncates toward zero, % takes the dividend's sign.
    function automatic void model(input logic [N-1:0] a, input logic [N-1:0] b,
                                  output logic [N-1:0] q, output logic [N-1:0] r,
                                  output logic dz, output logic ov);
        int ia;
        int ib;
        ia = int'($signed(a));
        ib = int'($signed(b));
        if (ib == 0) begin
            q  = '1;
            r  = a;
            dz = 1'b1;
            ov = 1'b0;
        end else begin
            q  = N'(ia / ib);
            r  = N'(ia % ib);
            dz = 1'b0;
            ov = (ia == -(2 ** (N - 1))) && (ib == -1);
        end
    endfunction

    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input int bp);
        logic [N-1:0] eq;
        logic [N-1:0] er;
        logic         ed;
        logic         eo;
        int           lat;
        int           low;
        int           explat;
        model(a, b, eq, er, ed, eo);
        explat = (b == '0) ? 1 : N + 2;

        @(negedge clk);
        in_valid  = 1'b1;
        A         = a;
        B         = b;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        A        = N'($urandom);
        B        = N'($urandom);
        lat      = 1;
        low      = in_ready ? 0 : 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (!in_ready) low++;
        end
        check($sformatf("latency %0d/%0d", $signed(a), $signed(b)), 64'(lat), 64'(explat));
        check("in_ready_low_while_busy", 64'(low), 64'(lat));
        check($sformatf("quotient %0d/%0d", $signed(a), $signed(b)), 64'(Quotient), 64'(eq));
        check($sformatf("remainder %0d/%0d", $signed(a), $signed(b)), 64'(Remainder), 64'(er));
        check("div_by_zero", 64'(DivByZero), 64'(ed));
        check("overflow", 64'(Overflow), 64'(eo));

        // Offer other operands while the result is held; none may be accepted.
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            A        = 8'd50;
            B        = 8'd3;
            @(posedge clk);
            #1;
            check("backpressure_hold",
                  64'({out_valid, in_ready, Overflow, DivByZero, Remainder, Quotient}),
                  64'({1'b1, 1'b0, eo, ed, er, eq}));
        end

        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("handshake_valid_ready", 64'({out_valid, in_ready}), 64'(2'b01));
        check("hold_after_handshake", 64'({Remainder, Quotient}), 64'({er, eq}));
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [N-1:0] ra;
        logic [N-1:0] rb;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = '0;
        B         = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", 64'(in_ready), 64'(1));
        check("reset_out_valid", 64'(out_valid), 64'(0));
        check("reset_quotient", 64'(Quotient), 64'(0));
        check("reset_remainder", 64'(Remainder), 64'(0));
        check("reset_flags", 64'({DivByZero, Overflow}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        do_op(8'd100, 8'd7, 0);
        check("const_q_100_7", 64'(Quotient), 64'(8'd14));
        check("const_r_100_7", 64'(Remainder), 64'(8'd2));
        do_op(-8'sd100, 8'd7, 0);
        check("const_q_m100_7", 64'(Quotient), 64'(8'hF2));
        check("const_r_m100_7", 64'(Remainder), 64'(8'hFE));
        do_op(8'd100, -8'sd7, 0);
        check("const_q_100_m7", 64'(Quotient), 64'(8'hF2));
        do_op(8'd25, 8'd0, 1);
        check("const_q_div0", 64'(Quotient), 64'(8'hFF));
        do_op(8'h80, 8'hFF, 0);
        check("const_q_ovf", 64'(Quotient), 64'(8'h80));
        do_op(8'h80, 8'd1, 0);
        do_op(8'd0, -8'sd5, 0);
        do_op(-8'sd3, 8'd9, 0);
        do_op(8'h7F, 8'h80, 0);
        do_op(8'd100, 8'd7, 5);

        // Abort an operation partway through CALC.
        @(negedge clk);
        in_valid = 1'b1;
        A        = 8'd50;
        B        = 8'd3;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_out_valid", 64'(out_valid), 64'(0));
        check("midreset_in_ready", 64'(in_ready), 64'(1));
        check("midreset_outputs", 64'({DivByZero, Overflow, Remainder, Quotient}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        do_op(8'd50, 8'd3, 0);
        check("const_q_50_3", 64'(Quotient), 64'(8'd16));
        check("const_r_50_3", 64'(Remainder), 64'(8'd2));

        for (int i = 0; i < 40; i++) begin
            ra = N'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                ra = 8'h80;
                rb = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'h01;
            end
            do_op(ra, rb, int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
